// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: accepts a byte, then sequences start, data
// (via the external serializer), optional parity and stop bits onto TX_OUT.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic [DATA_WIDTH-1:0] ser_p_data,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_bit;

  // Parity always comes from the latched word so mid-frame input changes are harmless.
  assign par_bit = (^word_q) ^ par_typ_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      word_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = 1'b1;
    busy_d    = (state_q != IDLE);
    ser_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          word_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          state_d   = START;
        end
      end
      START: begin
        tx_d    = 1'b0;
        state_d = DATA;
      end
      DATA: begin
        ser_en = 1'b1;
        tx_d   = ser_data;
        // No local bit counter: the serializer flags its last bit.
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx_d    = par_bit;
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ser_p_data = word_q;
  assign TX_OUT     = tx_q;
  assign Busy       = busy_q;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller for the UART transmit path. It accepts a parallel byte with a valid strobe and latches the data and the parity configuration. It then sequences start bit, data bits, optional parity bit and stop bit onto the serial line. The data bits themselves are shifted out by the downstream serializer, which this block enables, feeds and monitors through the `ser_en` / `ser_data` / `ser_done` handshake.

## Interface
- `DATA_WIDTH`, default 8: width of the parallel data word. The attached serializer terminates at 8 bits, so 8 is the only supported value.
- `CLK`  in  1  transmit bit clock; one UART bit per cycle.
- `RST`  in  1  reset, asynchronous, active-low.
- `P_DATA`  in  DATA_WIDTH  parallel word to transmit; sampled only at frame acceptance.
- `DATA_VALID`  in  1  request to transmit `P_DATA`; honoured only in IDLE.
- `PAR_EN`  in  1  1 = append a parity bit; sampled at acceptance.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity; sampled at acceptance.
- `ser_data`  in  1  current data bit from the serializer, combinational.
- `ser_done`  in  1  serializer is on its last data bit, combinational.
- `ser_en`  out  1  serializer advance enable; combinational, high only in state DATA.
- `ser_p_data`  out  DATA_WIDTH  latched word presented to the serializer.
- `TX_OUT`  out  1  serial line, registered; idle-high.
- `Busy`  out  1  frame in progress, registered.

## Operation
- States are IDLE, START, DATA, PARITY and STOP, with a binary-encoded state register.
- IDLE:
  - If `DATA_VALID` = 1 at a clock edge, latch `P_DATA` into `ser_p_data`, latch `PAR_EN` and `PAR_TYP`, and go to START.
  - Otherwise remain in IDLE.
- START: lasts one cycle, then go to DATA.
- DATA:
  - `ser_en` = 1.
  - Go to PARITY if `ser_done` = 1 and latched PAR_EN = 1.
  - Go to STOP if `ser_done` = 1 and latched PAR_EN = 0.
  - Otherwise stay. The block has no own bit counter; it relies on `ser_done`.
- PARITY: lasts one cycle, then go to STOP.
- STOP: lasts one cycle, then always go to IDLE. There is no STOP→START shortcut.
- Line mux (next value of `TX_OUT`):
  - IDLE → 1
  - START → 0
  - DATA → `ser_data`
  - PARITY → parity bit
  - STOP → 1
- Parity bit:
  - Even: XOR-reduce of the latched word.
  - Odd: inverse of the XOR-reduce.
  - Computed from `ser_p_data`, never from live `P_DATA`.
- Next value of `Busy` = (state ≠ IDLE).
- `DATA_VALID` while `Busy` = 1 is ignored and not queued. Changes on `P_DATA`, `PAR_EN` or `PAR_TYP` during a frame have no effect.
- Data bits go out LSB first, as the serializer presents them.

## Timing
- Reset values:
  - state = IDLE
  - `TX_OUT` = 1
  - `Busy` = 0
  - `ser_en` = 0
  - `ser_p_data` = 0
  - latched parity configuration = 0
- Reset mid-frame aborts immediately: the line returns high and the frame is not resumed. The serializer shares `RST`, so its bit counter restarts at 0.
- Acceptance at edge k gives the following schedule:
  - `TX_OUT` = 0 and `Busy` = 1 after edge k+1.
  - Data bit i is on `TX_OUT` after edge k+2+i, for i = 0..7.
  - With parity: parity bit after edge k+10, stop after edge k+11, `Busy` = 0 after edge k+12.
  - Without parity: stop after edge k+10, `Busy` = 0 after edge k+11.
- `ser_en` is high for exactly 8 consecutive cycles per frame. On the cycle where `ser_done` = 1 the serializer wraps its counter to 0, so it is ready for the next frame without reset.
- Frame length is 11 bit times with parity and 10 without.
- Back-to-back operation with `DATA_VALID` held high: the next acceptance occurs in the IDLE cycle after STOP. The line therefore shows stop plus one idle bit (2 high bit times) between frames.
- `ser_done` is ignored outside DATA.

## Test plan
- Reset, then idle 5 cycles → `TX_OUT` = 1, `Busy` = 0, `ser_en` = 0 throughout.
- `P_DATA` = 0xA5, `PAR_EN` = 1, `PAR_TYP` = 0, one-cycle `DATA_VALID` → `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,0,1; `Busy` high for 11 cycles; `ser_en` high for 8.
- Same data with `PAR_TYP` = 1 → parity bit = 1. With `PAR_EN` = 0 → 10-bit frame 0,1,0,1,0,0,1,0,1,1.
- During a 0x3C frame, pulse `DATA_VALID` with `P_DATA` = 0xFF at bit 3 → frame for 0x3C completes unchanged, and no second frame follows.
- `DATA_VALID` held high with 0x01 then 0x80, no parity → two frames separated by exactly 2 high bit times; second frame data reads 0x80.
- Assert `RST` during data bit 4 of a frame, release after 2 cycles → `TX_OUT` = 1 and `Busy` = 0 immediately. A new 0x55 request then produces a correct full frame.
